// File: rtl/matrix_mac_engine.sv
// -----------------------------------------------------------------------------
// matrix_mac_engine
//
// Iterative N x N signed matrix multiply, C = A * B, computed by a single
// multiply-accumulate unit. Operands live in internal A/B storage that is
// loaded through a simple write port while the engine is idle. Each C element
// takes N accumulate cycles and is then presented on a valid/ready output in
// row-major order.
//
// Optional feature macro: MATRIX_MAC_RELU_EN
//   defined   : out_data = (acc < 0) ? 0 : acc
//   undefined : out_data = acc (raw signed sum)
//
// Parameters
//   N       matrix dimension (2..16)
//   DATA_W  operand width, signed
//   ACC_W   accumulator / result width, signed, ACC_W >= 2*DATA_W
//
// Ports
//   clk, rst              clock, synchronous active-high reset
//   wr_en/wr_sel/wr_addr  operand write (sel 0 = A, 1 = B), row-major index
//   wr_data               operand value
//   start                 begin a multiply (sampled only when idle)
//   busy                  high whenever not idle
//   done                  one-cycle pulse after the last element handshake
//   out_valid/out_ready   result handshake
//   out_data              C element (ReLU applied if enabled)
//   out_row/out_col       indices of the presented element
// -----------------------------------------------------------------------------
module matrix_mac_engine #(
    parameter int N      = 2,
    parameter int DATA_W = 64,
    parameter int ACC_W  = 128
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        wr_en,
    input  logic                        wr_sel,
    input  logic [$clog2(N*N)-1:0]      wr_addr,
    input  logic [DATA_W-1:0]           wr_data,
    input  logic                        start,
    output logic                        busy,
    output logic                        done,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [ACC_W-1:0]            out_data,
    output logic [$clog2(N)-1:0]        out_row,
    output logic [$clog2(N)-1:0]        out_col
);

    localparam int AW = $clog2(N*N);
    localparam int IW = $clog2(N);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        OUT  = 2'd2
    } state_t;

    // Full-precision signed product, sign-extended to the accumulator width.
    function automatic logic signed [ACC_W-1:0] mul_sext(
        input logic signed [DATA_W-1:0] a,
        input logic signed [DATA_W-1:0] b
    );
        logic signed [2*DATA_W-1:0] p;
        p = (2*DATA_W)'(a) * (2*DATA_W)'(b);
        return ACC_W'(p);
    endfunction

    // Clamp negative sums to zero.
    function automatic logic signed [ACC_W-1:0] relu(
        input logic signed [ACC_W-1:0] v
    );
        return v[ACC_W-1] ? '0 : v;
    endfunction

    state_t                    state;
    state_t                    state_nxt;
    logic [IW-1:0]             i_idx;
    logic [IW-1:0]             j_idx;
    logic [IW-1:0]             k_idx;
    logic signed [ACC_W-1:0]   acc;
    logic                      done_r;

    logic signed [DATA_W-1:0]  a_mem [N*N];
    logic signed [DATA_W-1:0]  b_mem [N*N];

    // A write that lands in the same cycle as an accepted start must not
    // disturb the run it starts, so it is parked here and committed to
    // storage when the run completes.
    logic                      pend_vld;
    logic                      pend_sel;
    logic [AW-1:0]             pend_addr;
    logic [DATA_W-1:0]         pend_data;

    logic [AW-1:0]             a_idx;
    logic [AW-1:0]             b_idx;
    logic                      last_k;
    logic                      last_i;
    logic                      last_j;
    logic                      hs;
    logic                      final_hs;

    assign a_idx    = AW'(int'(i_idx) * N + int'(k_idx));
    assign b_idx    = AW'(int'(k_idx) * N + int'(j_idx));
    assign last_k   = (k_idx == IW'(N-1));
    assign last_i   = (i_idx == IW'(N-1));
    assign last_j   = (j_idx == IW'(N-1));
    assign hs       = (state == OUT) && out_ready;
    assign final_hs = hs && last_i && last_j;

    assign busy      = (state != IDLE);
    assign done      = done_r;
    assign out_valid = (state == OUT);
    assign out_row   = i_idx;
    assign out_col   = j_idx;

`ifdef MATRIX_MAC_RELU_EN
    assign out_data = relu(acc);
`else
    assign out_data = acc;
`endif

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (start)  state_nxt = MAC;
            MAC:  if (last_k) state_nxt = OUT;
            OUT:  if (hs)     state_nxt = final_hs ? IDLE : MAC;
            default:          state_nxt = IDLE;
        endcase
    end

    // State, indices, accumulator and operand storage
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            i_idx     <= '0;
            j_idx     <= '0;
            k_idx     <= '0;
            acc       <= '0;
            done_r    <= 1'b0;
            pend_vld  <= 1'b0;
            pend_sel  <= 1'b0;
            pend_addr <= '0;
            pend_data <= '0;
            for (int e = 0; e < N*N; e++) begin
                a_mem[e] <= '0;
                b_mem[e] <= '0;
            end
        end else begin
            state  <= state_nxt;
            done_r <= final_hs;
            case (state)
                IDLE: begin
                    if (start) begin
                        i_idx <= '0;
                        j_idx <= '0;
                        k_idx <= '0;
                        acc   <= '0;
                    end
                    if (wr_en) begin
                        if (start) begin
                            pend_vld  <= 1'b1;
                            pend_sel  <= wr_sel;
                            pend_addr <= wr_addr;
                            pend_data <= wr_data;
                        end else if (wr_sel) begin
                            b_mem[wr_addr] <= wr_data;
                        end else begin
                            a_mem[wr_addr] <= wr_data;
                        end
                    end
                end
                // Accumulate one partial product per cycle; wraps mod 2^ACC_W.
                MAC: begin
                    acc   <= acc + mul_sext(a_mem[a_idx], b_mem[b_idx]);
                    k_idx <= last_k ? '0 : k_idx + IW'(1);
                end
                OUT: begin
                    if (hs && !final_hs) begin
                        acc   <= '0;
                        k_idx <= '0;
                        if (last_j) begin
                            j_idx <= '0;
                            i_idx <= i_idx + IW'(1);
                        end else begin
                            j_idx <= j_idx + IW'(1);
                        end
                    end
                    if (final_hs && pend_vld) begin
                        pend_vld <= 1'b0;
                        if (pend_sel) b_mem[pend_addr] <= pend_data;
                        else          a_mem[pend_addr] <= pend_data;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_matrix_mac_engine.sv
module tb_matrix_mac_engine;

    logic         clk = 1'b0;
    logic         rst;
    logic         wr_en, wr_sel, start, out_ready;
    logic [1:0]   wr_addr;
    logic [63:0]  wr_data;
    logic         busy, done, out_valid;
    logic [127:0] out_data;
    logic         out_row, out_col;

    logic         wr_en3, wr_sel3, start3, out_ready3;
    logic [3:0]   wr_addr3;
    logic [63:0]  wr_data3;
    logic         busy3, done3, out_valid3;
    logic [127:0] out_data3;
    logic [1:0]   out_row3, out_col3;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int t0;
    logic [127:0] expv [9];

    always #5 clk = ~clk;

    matrix_mac_engine #(.N(2), .DATA_W(64), .ACC_W(128)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_sel(wr_sel), .wr_addr(wr_addr),
        .wr_data(wr_data), .start(start), .busy(busy), .done(done),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_row(out_row), .out_col(out_col)
    );

    matrix_mac_engine #(.N(3), .DATA_W(64), .ACC_W(128)) dut3 (
        .clk(clk), .rst(rst), .wr_en(wr_en3), .wr_sel(wr_sel3), .wr_addr(wr_addr3),
        .wr_data(wr_data3), .start(start3), .busy(busy3), .done(done3),
        .out_valid(out_valid3), .out_ready(out_ready3), .out_data(out_data3),
        .out_row(out_row3), .out_col(out_col3)
    );

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic wr(input int s, input int a, input longint d);
        wr_en   = 1'b1;
        wr_sel  = s[0];
        wr_addr = 2'(a);
        wr_data = 64'(d);
        step();
        wr_en   = 1'b0;
    endtask

    task automatic wr3(input int s, input int a, input longint d);
        wr_en3   = 1'b1;
        wr_sel3  = s[0];
        wr_addr3 = 4'(a);
        wr_data3 = 64'(d);
        step();
        wr_en3   = 1'b0;
    endtask

    task automatic set4(input longint a, input longint b, input longint c, input longint d);
        expv[0] = 128'(a);
        expv[1] = 128'(b);
        expv[2] = 128'(c);
        expv[3] = 128'(d);
    endtask

    task automatic wait_valid();
        int n = 0;
        while (!out_valid && n < 40) begin
            step();
            n++;
        end
        check("valid_timeout", 128'(out_valid), 128'(1));
    endtask

    // Consume the four C elements, optionally stalling each one for 'hold' cycles.
    task automatic collect(input int hold);
        logic [127:0] d0;
        logic         r0, c0;
        for (int e = 0; e < 4; e++) begin
            wait_valid();
            if (hold > 0) begin
                out_ready = 1'b0;
                d0 = out_data;
                r0 = out_row;
                c0 = out_col;
                for (int h = 0; h < hold; h++) begin
                    step();
                    check("bp_valid", 128'(out_valid), 128'(1));
                    check("bp_data", out_data, d0);
                    check("bp_row", 128'(out_row), 128'(r0));
                    check("bp_col", 128'(out_col), 128'(c0));
                end
                out_ready = 1'b1;
            end
            check("c_data", out_data, expv[e]);
            check("c_row", 128'(out_row), 128'(e / 2));
            check("c_col", 128'(out_col), 128'(e % 2));
            step();
            if (e < 3) check("valid_low_mac", 128'(out_valid), 128'(0));
        end
    endtask

    task automatic run(input int hold);
        start = 1'b1;
        step();
        start = 1'b0;
        collect(hold);
        check("done_pulse", 128'(done), 128'(1));
        check("busy_at_done", 128'(busy), 128'(0));
        step();
        check("done_clear", 128'(done), 128'(0));
    endtask

    initial begin
        logic [127:0] neg5;
        int n;
        rst = 1'b1; wr_en = 1'b0; wr_sel = 1'b0; wr_addr = '0; wr_data = '0;
        start = 1'b0; out_ready = 1'b1;
        wr_en3 = 1'b0; wr_sel3 = 1'b0; wr_addr3 = '0; wr_data3 = '0;
        start3 = 1'b0; out_ready3 = 1'b1;
        step();
        step();
        rst = 1'b0;

        // Reset state
        check("rst_busy", 128'(busy), 128'(0));
        check("rst_done", 128'(done), 128'(0));
        check("rst_valid", 128'(out_valid), 128'(0));
        check("rst_data", out_data, 128'(0));
        check("rst_row", 128'(out_row), 128'(0));
        check("rst_col", 128'(out_col), 128'(0));

        // Basic product with latency checks
        wr(0, 0, 1); wr(0, 1, 2); wr(0, 2, 3); wr(0, 3, 4);
        wr(1, 0, 5); wr(1, 1, 6); wr(1, 2, 7); wr(1, 3, 8);
        set4(19, 22, 43, 50);
        start = 1'b1;
        step();
        t0 = cyc;
        start = 1'b0;
        check("busy_rise", 128'(busy), 128'(1));
        check("valid_t0", 128'(out_valid), 128'(0));
        step();
        check("valid_t1", 128'(out_valid), 128'(0));
        step();
        check("valid_t2", 128'(out_valid), 128'(1));
        collect(0);
        check("done_pulse", 128'(done), 128'(1));
        check("done_latency", 128'(cyc - t0), 128'(12));
        check("busy_at_done", 128'(busy), 128'(0));
        step();
        check("done_clear", 128'(done), 128'(0));

        // Backpressure
        run(5);

        // Write and start while busy are ignored
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        check("in_mac", 128'(busy), 128'(1));
        wr_en = 1'b1; wr_sel = 1'b0; wr_addr = 2'd0; wr_data = 64'd100; start = 1'b1;
        step();
        wr_en = 1'b0; start = 1'b0;
        collect(0);
        check("done_pulse", 128'(done), 128'(1));
        step();
        run(0);

        // Write coincident with start: current run sees old value, next run new
        wr_en = 1'b1; wr_sel = 1'b0; wr_addr = 2'd0; wr_data = 64'd2; start = 1'b1;
        step();
        wr_en = 1'b0; start = 1'b0;
        collect(0);
        check("done_pulse", 128'(done), 128'(1));
        step();
        set4(24, 28, 43, 50);
        run(0);
        wr(0, 0, 1);

        // Negative result
        wr(0, 0, -1); wr(0, 1, 0); wr(0, 2, 0); wr(0, 3, 1);
        wr(1, 0, 5);  wr(1, 1, 0); wr(1, 2, 0); wr(1, 3, 1);
        neg5 = -128'sd5;
`ifdef MATRIX_MAC_RELU_EN
        set4(0, 0, 0, 1);
`else
        set4(-5, 0, 0, 1);
        check("neg_const", expv[0], neg5);
`endif
        run(0);

        // Reset during OUT
        start = 1'b1;
        step();
        start = 1'b0;
        wait_valid();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("mid_rst_busy", 128'(busy), 128'(0));
        check("mid_rst_valid", 128'(out_valid), 128'(0));
        check("mid_rst_data", out_data, 128'(0));
        check("mid_rst_row", 128'(out_row), 128'(0));
        check("mid_rst_col", 128'(out_col), 128'(0));
        check("mid_rst_done", 128'(done), 128'(0));
        step();
        check("mid_rst_done2", 128'(done), 128'(0));
        set4(0, 0, 0, 0);
        run(0);

        // N=3 wrap-around: identity times 1..9
        wr3(0, 0, 1); wr3(0, 4, 1); wr3(0, 8, 1);
        for (int e = 0; e < 9; e++) wr3(1, e, e + 1);
        start3 = 1'b1;
        step();
        t0 = cyc;
        start3 = 1'b0;
        for (int e = 0; e < 9; e++) begin
            n = 0;
            while (!out_valid3 && n < 40) begin
                step();
                n++;
            end
            check("n3_valid_timeout", 128'(out_valid3), 128'(1));
            check("n3_data", out_data3, 128'(e + 1));
            check("n3_row", 128'(out_row3), 128'(e / 3));
            check("n3_col", 128'(out_col3), 128'(e % 3));
            step();
        end
        check("n3_done", 128'(done3), 128'(1));
        check("n3_done_latency", 128'(cyc - t0), 128'(36));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
